// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: bridge between the sequencer's memory requests and a
// synchronous single-port word SRAM. Stores are posted through a one-entry
// write buffer; loads are issued, captured, extended and returned on the bus
// with a one-cycle mem_data_ready pulse.
module mem_bus_ctrl #(
  parameter int AW         = 17,
  parameter int RD_LATENCY = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   addr,
  input  logic [31:0]   bus_in,
  output logic [31:0]   bus_out,
  output logic          bus_oe,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [3:0]    mem_size,
  input  logic          mem_addr_ready,
  output logic          mem_data_ready,
  output logic [AW-1:0] sram_addr,
  output logic          sram_cs,
  output logic          sram_we,
  output logic [3:0]    sram_be,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata,
  output logic          wr_overflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPT,
    S_RESP,
    S_DONE
  } state_t;

  // WAIT spans RD_LATENCY cycles so CAPT always samples settled SRAM data
  localparam logic [2:0] WAIT_LAST = 3'(RD_LATENCY - 1);

  localparam logic [3:0] SIZE_BYTE = 4'b1000;
  localparam logic [3:0] SIZE_HALF = 4'b0010;

  state_t         state;
  state_t         state_next;
  logic [2:0]     wait_cnt;

  logic           buf_full;
  logic [AW-1:0]  buf_addr;
  logic [3:0]     buf_be;
  logic [31:0]    buf_wdata;

  logic [AW-1:0]  rd_addr;
  logic [1:0]     rd_off;
  logic [3:0]     rd_size;

  logic           drain;
  logic           accept;

  logic [4:0]     st_shift;
  logic [3:0]     st_be;
  logic [31:0]    st_wdata;

  logic [4:0]     ld_shift;
  logic [15:0]    ld_half;
  logic [31:0]    ld_ext;

  logic           unused_addr_bits;

  assign unused_addr_bits = ^addr[31:AW+2];

  // a buffered write always wins the SRAM port over a new read
  assign drain  = (state == S_IDLE) && buf_full;
  assign accept = (state == S_IDLE) && !buf_full && mem_addr_ready && mem_read;

  // byte-lane steering of the incoming store, computed at capture time
  always_comb begin
    st_shift = {addr[1:0], 3'b000};
    st_be    = 4'b1111;
    st_wdata = bus_in;
    case (mem_size)
      SIZE_BYTE: begin
        st_be    = 4'b0001 << addr[1:0];
        st_wdata = bus_in << st_shift;
      end
      SIZE_HALF: begin
        st_be    = 4'b0011 << addr[1:0];
        st_wdata = bus_in << st_shift;
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = bus_in;
      end
    endcase
  end

  // shift the addressed byte/half down to bit 0 and extend per load type
  always_comb begin
    ld_shift = {rd_off, 3'b000};
    ld_half  = 16'(sram_rdata >> ld_shift);
    case (rd_size)
      4'b1000: ld_ext = {{24{ld_half[7]}}, ld_half[7:0]};
      4'b0100: ld_ext = {24'h000000, ld_half[7:0]};
      4'b0010: ld_ext = {{16{ld_half[15]}}, ld_half};
      4'b0001: ld_ext = {16'h0000, ld_half};
      default: ld_ext = sram_rdata;
    endcase
  end

  // one-entry write buffer; a write landing on the drain edge refills it
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_full    <= 1'b0;
      buf_addr    <= '0;
      buf_be      <= '0;
      buf_wdata   <= '0;
      wr_overflow <= 1'b0;
    end else if (mem_write) begin
      if (!buf_full || drain) begin
        buf_full  <= 1'b1;
        buf_addr  <= addr[AW+1:2];
        buf_be    <= st_be;
        buf_wdata <= st_wdata;
      end else begin
        wr_overflow <= 1'b1;
      end
    end else if (drain) begin
      buf_full <= 1'b0;
    end
  end

  // remember the accepted read so the request inputs are free afterwards
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr <= '0;
      rd_off  <= '0;
      rd_size <= '0;
    end else if (accept) begin
      rd_addr <= addr[AW+1:2];
      rd_off  <= addr[1:0];
      rd_size <= mem_size;
    end
  end

  // count cycles spent waiting on the SRAM read pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt + 3'd1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // load result register; holds its value outside CAPT
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_out <= '0;
    end else if (state == S_CAPT) begin
      bus_out <= ld_ext;
    end
  end

  // next-state and SRAM/bus strobes
  always_comb begin
    state_next     = state;
    sram_cs        = 1'b0;
    sram_we        = 1'b0;
    sram_be        = 4'b0000;
    sram_addr      = '0;
    sram_wdata     = '0;
    mem_data_ready = 1'b0;
    bus_oe         = 1'b0;
    case (state)
      S_IDLE: begin
        if (buf_full) begin
          sram_cs    = 1'b1;
          sram_we    = 1'b1;
          sram_be    = buf_be;
          sram_addr  = buf_addr;
          sram_wdata = buf_wdata;
        end else if (accept) begin
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        sram_cs    = 1'b1;
        sram_be    = 4'b1111;
        sram_addr  = rd_addr;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          state_next = S_CAPT;
        end
      end
      S_CAPT: begin
        state_next = S_RESP;
      end
      S_RESP: begin
        mem_data_ready = 1'b1;
        bus_oe         = 1'b1;
        state_next     = S_DONE;
      end
      S_DONE: begin
        if (!mem_addr_ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: drives two controller instances (read latency 1 and 3)
// against behavioural SRAMs and checks results against a byte-level memory
// model with directed and randomized loads and stores.
module tb_mem_bus_ctrl;

  localparam int AW = 17;

  localparam logic [3:0] SZ_LB  = 4'b1000;
  localparam logic [3:0] SZ_LBU = 4'b0100;
  localparam logic [3:0] SZ_LH  = 4'b0010;
  localparam logic [3:0] SZ_LHU = 4'b0001;
  localparam logic [3:0] SZ_W   = 4'b0000;
  localparam logic [3:0] SZ_SB  = 4'b1000;
  localparam logic [3:0] SZ_SH  = 4'b0010;
  localparam logic [3:0] SZ_SW  = 4'b0000;

  logic clk = 1'b0;
  logic reset;

  logic [31:0]   addr, bus_in, bus_out, sram_wdata, sram_rdata;
  logic          bus_oe, mem_read, mem_write, mem_addr_ready, mem_data_ready;
  logic          sram_cs, sram_we, wr_overflow;
  logic [3:0]    mem_size, sram_be;
  logic [AW-1:0] sram_addr;

  logic [31:0]   l3_addr, l3_bus_in, l3_bus_out, l3_wdata, l3_rdata;
  logic          l3_bus_oe, l3_mem_read, l3_mem_write, l3_mar, l3_mdr;
  logic          l3_cs, l3_we, l3_ovf;
  logic [3:0]    l3_mem_size, l3_be;
  logic [AW-1:0] l3_sram_addr;

  logic          init_we;
  logic [7:0]    init_idx;
  logic [31:0]   init_data;

  logic [31:0]   sram_mem [0:255];
  logic [31:0]   mem3 [0:255];
  logic [31:0]   p1, p2;
  logic          v1, v2;

  logic [7:0]    bmem [0:1023];
  logic [31:0]   ref3 [0:255];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_ctrl #(.AW(AW), .RD_LATENCY(1)) u_dut (
    .clk(clk), .reset(reset), .addr(addr), .bus_in(bus_in), .bus_out(bus_out),
    .bus_oe(bus_oe), .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .mem_addr_ready(mem_addr_ready), .mem_data_ready(mem_data_ready),
    .sram_addr(sram_addr), .sram_cs(sram_cs), .sram_we(sram_we), .sram_be(sram_be),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .wr_overflow(wr_overflow)
  );

  mem_bus_ctrl #(.AW(AW), .RD_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .addr(l3_addr), .bus_in(l3_bus_in), .bus_out(l3_bus_out),
    .bus_oe(l3_bus_oe), .mem_read(l3_mem_read), .mem_write(l3_mem_write), .mem_size(l3_mem_size),
    .mem_addr_ready(l3_mar), .mem_data_ready(l3_mdr),
    .sram_addr(l3_sram_addr), .sram_cs(l3_cs), .sram_we(l3_we), .sram_be(l3_be),
    .sram_wdata(l3_wdata), .sram_rdata(l3_rdata), .wr_overflow(l3_ovf)
  );

  // single-cycle-latency SRAM behind the first instance
  always @(posedge clk) begin
    if (init_we) begin
      sram_mem[init_idx] <= init_data;
    end else if (sram_cs && sram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (sram_be[i]) sram_mem[sram_addr[7:0]][8*i +: 8] <= sram_wdata[8*i +: 8];
      end
    end else if (sram_cs) begin
      sram_rdata <= sram_mem[sram_addr[7:0]];
    end
  end

  // three-stage read pipeline SRAM behind the second instance
  always @(posedge clk) begin
    if (init_we) begin
      mem3[init_idx] <= init_data;
    end else if (l3_cs && l3_we) begin
      for (int i = 0; i < 4; i++) begin
        if (l3_be[i]) mem3[l3_sram_addr[7:0]][8*i +: 8] <= l3_wdata[8*i +: 8];
      end
    end
    v1 <= l3_cs && !l3_we;
    p1 <= mem3[l3_sram_addr[7:0]];
    v2 <= v1;
    p2 <= p1;
    if (v2) l3_rdata <= p2;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic mar, input logic wr,
                               input logic [31:0] a, input logic [3:0] sz, input logic [31:0] d);
    mem_read       = rd;
    mem_addr_ready = mar;
    mem_write      = wr;
    addr           = a;
    mem_size       = sz;
    bus_in         = d;
  endtask

  // byte-level memory view: what a load of this size at this address returns
  function automatic logic [31:0] loadExp(input logic [31:0] a, input logic [3:0] sz);
    logic [9:0] ba;
    logic [9:0] wa;
    logic [7:0] b0;
    logic [7:0] b1;
    ba = a[9:0];
    wa = {a[9:2], 2'b00};
    b0 = bmem[ba];
    b1 = bmem[ba + 10'd1];
    case (sz)
      SZ_LB:   return {{24{b0[7]}}, b0};
      SZ_LBU:  return {24'h0, b0};
      SZ_LH:   return {{16{b1[7]}}, b1, b0};
      SZ_LHU:  return {16'h0, b1, b0};
      default: return {bmem[wa + 10'd3], bmem[wa + 10'd2], bmem[wa + 10'd1], bmem[wa]};
    endcase
  endfunction

  // apply a store to the byte model and derive the lanes it must touch
  task automatic storeModel(input logic [31:0] a, input logic [3:0] sz, input logic [31:0] d,
                            output logic [3:0] be, output logic [31:0] lanes, output logic [31:0] mask);
    int n;
    logic [9:0] base;
    n    = (sz == SZ_SB) ? 1 : ((sz == SZ_SH) ? 2 : 4);
    base = (n == 4) ? {a[9:2], 2'b00} : a[9:0];
    be    = '0;
    lanes = '0;
    mask  = '0;
    for (int j = 0; j < n; j++) begin
      bmem[base + 10'(j)] = d[8*j +: 8];
      be[base[1:0] + 2'(j)] = 1'b1;
      lanes[8*(int'(base[1:0]) + j) +: 8] = d[8*j +: 8];
      mask[8*(int'(base[1:0]) + j) +: 8]  = 8'hFF;
    end
  endtask

  // capture a store and check the drain strobe in the following cycle
  task automatic doWrite(input logic [31:0] a, input logic [3:0] sz, input logic [31:0] d);
    logic [3:0]  be;
    logic [31:0] lanes;
    logic [31:0] mask;
    applyStimulus(1'b0, 1'b0, 1'b1, a, sz, d);
    tick();
    mem_write = 1'b0;
    storeModel(a, sz, d, be, lanes, mask);
    checkOutput("drain_cs_we", 32'({sram_cs, sram_we}), 32'h3);
    checkOutput("drain_be", 32'(sram_be), 32'(be));
    checkOutput("drain_lanes", sram_wdata & mask, lanes);
    checkOutput("drain_addr", 32'(sram_addr), 32'(a[AW+1:2]));
  endtask

  // issue a load, watch up to 16 cycles, check data, timing and strobe counts
  task automatic doRead(input logic [31:0] a, input logic [3:0] sz, input int extra);
    logic [31:0] exp_val;
    logic [31:0] got;
    logic        oe;
    int          pk;
    int          npulse;
    int          nread;
    int          first_cs;
    exp_val  = loadExp(a, sz);
    got      = 32'hx;
    oe       = 1'b0;
    pk       = -1;
    npulse   = 0;
    nread    = 0;
    first_cs = -1;
    applyStimulus(1'b1, 1'b1, 1'b0, a, sz, 32'h0);
    for (int k = 0; k < 16; k++) begin
      tick();
      if (sram_cs && !sram_we) begin
        nread++;
        if (first_cs < 0) first_cs = k;
      end
      if (mem_data_ready) begin
        npulse++;
        if (pk < 0) begin
          pk  = k;
          got = bus_out;
          oe  = bus_oe;
        end
      end
    end
    checkOutput("rd_data", got, exp_val);
    checkOutput("rd_pulse_cycle", 32'(pk), 32'(3 + extra));
    checkOutput("rd_pulse_count", 32'(npulse), 32'd1);
    checkOutput("rd_issue_cycle", 32'(first_cs), 32'(extra));
    checkOutput("rd_cs_count", 32'(nread), 32'd1);
    checkOutput("rd_oe", 32'(oe), 32'd1);
    checkOutput("rd_hold", bus_out, exp_val);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, SZ_W, 32'h0);
    tick();
    tick();
  endtask

  initial begin : main
    logic [31:0] r;
    logic [31:0] ra;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] a3;
    logic [3:0]  be;
    logic [31:0] lanes;
    logic [31:0] mask;
    int          op;
    int          pk;
    int          npulse;
    int          nread;
    logic [31:0] got;
    logic        oe;
    logic [31:0] issue_addr;

    reset = 1'b1;
    init_we = 1'b0;
    init_idx = '0;
    init_data = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, SZ_W, 32'h0);
    l3_addr = '0; l3_bus_in = '0; l3_mem_read = 1'b0; l3_mem_write = 1'b0;
    l3_mar = 1'b0; l3_mem_size = SZ_W;

    // fill both SRAMs and the reference views with the same random words
    for (int w = 0; w < 256; w++) begin
      r = $urandom;
      init_idx  = 8'(w);
      init_data = r;
      init_we   = 1'b1;
      ref3[w]   = r;
      for (int i = 0; i < 4; i++) bmem[4*w + i] = r[8*i +: 8];
      tick();
    end
    init_we = 1'b0;
    tick();

    $display("[TB] reset state");
    checkOutput("rst_mdr", 32'(mem_data_ready), 32'd0);
    checkOutput("rst_oe", 32'(bus_oe), 32'd0);
    checkOutput("rst_cs", 32'(sram_cs), 32'd0);
    checkOutput("rst_ovf", 32'(wr_overflow), 32'd0);
    checkOutput("rst_bus_out", bus_out, 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("idle_cs", 32'({sram_cs, sram_we, sram_be}), 32'd0);

    $display("[TB] byte loads with sign and zero extension");
    doWrite(32'h100, SZ_SW, 32'h8000_00F4);
    tick();
    doRead(32'h100, SZ_LB, 0);
    doRead(32'h100, SZ_LBU, 0);

    $display("[TB] halfword loads");
    doRead(32'h102, SZ_LHU, 0);
    doWrite(32'h100, SZ_SW, 32'h1234_5678);
    tick();
    doRead(32'h101, SZ_LH, 0);

    $display("[TB] store lane steering");
    doWrite(32'h103, SZ_SB, 32'h0000_00AB);
    tick();
    doWrite(32'h102, SZ_SH, 32'h0000_CAFE);
    tick();
    doWrite(32'h107, SZ_SW, 32'h0BAD_F00D);
    tick();
    doRead(32'h100, SZ_W, 0);
    doRead(32'h104, SZ_W, 0);

    $display("[TB] store then immediate load of same word");
    doWrite(32'h200, SZ_SW, 32'hDEAD_BEEF);
    doRead(32'h200, SZ_W, 1);

    $display("[TB] request level drops mid-read");
    ra = 32'h104;
    applyStimulus(1'b1, 1'b1, 1'b0, ra, SZ_W, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, SZ_W, 32'h0);
    pk = -1;
    got = 32'hx;
    for (int k = 1; k < 16; k++) begin
      tick();
      if (mem_data_ready && pk < 0) begin
        pk  = k;
        got = bus_out;
      end
    end
    checkOutput("trap_pulse_cycle", 32'(pk), 32'd3);
    checkOutput("trap_data", got, loadExp(ra, SZ_W));

    $display("[TB] multi-bit size treated as word");
    doRead(32'h101, 4'b1100, 0);

    $display("[TB] writes during read in flight and overflow");
    d1 = $urandom;
    d2 = $urandom;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h300, SZ_W, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h310, SZ_SW, d1);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h314, SZ_SW, d2);
    tick();
    mem_write = 1'b0;
    checkOutput("ovf_set", 32'(wr_overflow), 32'd1);
    pk = -1;
    got = 32'hx;
    for (int k = 3; k < 16; k++) begin
      if (mem_data_ready && pk < 0) begin
        pk  = k - 1;
        got = bus_out;
      end
      tick();
    end
    checkOutput("ovf_rd_pulse_cycle", 32'(pk), 32'd3);
    checkOutput("ovf_rd_data", got, loadExp(32'h300, SZ_W));
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, SZ_W, 32'h0);
    tick();
    storeModel(32'h310, SZ_SW, d1, be, lanes, mask);
    checkOutput("ovf_drain_addr", 32'(sram_addr), 32'(32'h310 >> 2));
    checkOutput("ovf_drain_cs_we", 32'({sram_cs, sram_we}), 32'h3);
    tick();
    doRead(32'h310, SZ_W, 0);
    doRead(32'h314, SZ_W, 0);
    checkOutput("ovf_sticky", 32'(wr_overflow), 32'd1);

    $display("[TB] reset during read wait with buffered write");
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h320, SZ_W, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h324, SZ_SW, 32'h5555_AAAA);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, SZ_W, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("mid_rst_outputs", 32'({mem_data_ready, bus_oe, sram_cs, sram_we, sram_be, wr_overflow}), 32'd0);
    checkOutput("mid_rst_bus_out", bus_out, 32'd0);
    npulse = 0;
    nread = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (mem_data_ready) npulse++;
      if (sram_cs) nread++;
    end
    checkOutput("mid_rst_no_pulse", 32'(npulse), 32'd0);
    checkOutput("mid_rst_no_cs", 32'(nread), 32'd0);
    doRead(32'h324, SZ_W, 0);
    doRead(32'h320, SZ_W, 0);

    $display("[TB] randomized loads and stores");
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 7));
      ra = 32'($urandom_range(0, 1023));
      r  = $urandom;
      case (op)
        0: doRead(ra, SZ_LB, 0);
        1: doRead(ra, SZ_LBU, 0);
        2: begin ra[1:0] = 2'($urandom_range(0, 2)); doRead(ra, SZ_LH, 0); end
        3: begin ra[1:0] = 2'($urandom_range(0, 2)); doRead(ra, SZ_LHU, 0); end
        4: doRead(ra, (i % 2 == 0) ? SZ_W : 4'b0101, 0);
        5: begin doWrite(ra, SZ_SB, r); tick(); end
        6: begin ra[1:0] = 2'($urandom_range(0, 2)); doWrite(ra, SZ_SH, r); tick(); end
        default: begin doWrite(ra, SZ_SW, r); tick(); end
      endcase
    end

    $display("[TB] read latency 3 with held request level");
    a3 = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
    l3_addr = a3;
    l3_mem_size = SZ_W;
    l3_mem_read = 1'b1;
    l3_mar = 1'b1;
    pk = -1;
    npulse = 0;
    nread = 0;
    got = 32'hx;
    oe = 1'b0;
    issue_addr = 32'hx;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (l3_cs) begin
        nread++;
        issue_addr = 32'(l3_sram_addr);
      end
      if (l3_mdr) begin
        npulse++;
        if (pk < 0) begin
          pk  = k;
          got = l3_bus_out;
          oe  = l3_bus_oe;
        end
      end
    end
    l3_mar = 1'b0;
    l3_mem_read = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (l3_cs) nread++;
    end
    checkOutput("lat3_pulse_cycle", 32'(pk), 32'd5);
    checkOutput("lat3_pulse_count", 32'(npulse), 32'd1);
    checkOutput("lat3_cs_count", 32'(nread), 32'd1);
    checkOutput("lat3_issue_addr", issue_addr, 32'(a3[AW+1:2]));
    checkOutput("lat3_data", got, ref3[a3[9:2]]);
    checkOutput("lat3_oe", 32'(oe), 32'd1);
    checkOutput("lat3_ovf", 32'(l3_ovf), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
